order_book_pipelined: RTL and testbench

Parametrised single-side limit order book. It accepts add, cancel and execute requests over a valid/ready handshake and keeps a per-order table and per-price-level aggregate quantity. It publishes best price and best-level quantity through a fully pipelined reduction tree. It sits after the feed decoder, one instance per side (bid: IS_MAX=1, ask: IS_MAX=0), and drives the strategy logic.

---
 rtl/order_book_pipelined.sv | 256 +++++++++++++++++++++++++
 tb/tb_order_book_pipelined.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/order_book_pipelined.sv
// rtl/order_book_pipelined.sv - single-side limit order book with pipelined best-price tree
// Requests run IDLE->LOOKUP->COMMIT; a registered heap-ordered tree reduces the level array to best price/qty.
module order_book_pipelined #(
  parameter int PRICE_W = 7,
  parameter int ORDER_W = 8,
  parameter int QTY_W   = 16,
  parameter int IS_MAX  = 1,
  parameter int LVL_W   = QTY_W + ORDER_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [1:0]           req_op_in,
  input  logic [ORDER_W-1:0]   req_order_id_in,
  input  logic [PRICE_W-1:0]   req_price_in,
  input  logic [QTY_W-1:0]     req_qty_in,
  output logic                 resp_valid_out,
  output logic [1:0]           resp_code_out,
  output logic [QTY_W-1:0]     resp_qty_out,
  output logic                 best_valid_out,
  output logic [PRICE_W-1:0]   best_price_out,
  output logic [LVL_W-1:0]     best_qty_out,
  output logic                 best_stable_out,
  output logic [ORDER_W:0]     size_out
);

  localparam int NLVL  = 1 << PRICE_W;
  localparam int NORD  = 1 << ORDER_W;
  localparam int CNT_W = $clog2(PRICE_W + 2);

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_CANCEL = 2'd2;
  localparam logic [1:0] OP_EXEC   = 2'd3;

  localparam logic [1:0] RC_OK      = 2'd0;
  localparam logic [1:0] RC_UNKNOWN = 2'd1;
  localparam logic [1:0] RC_DUP     = 2'd2;
  localparam logic [1:0] RC_BAD_QTY = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_COMMIT} state_t;
  state_t state_q, state_d;

  logic [1:0]         op_q;
  logic [ORDER_W-1:0] id_q;
  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0]   qty_q;
  logic [QTY_W-1:0]   slot_qty_q;
  logic [PRICE_W-1:0] slot_price_q;

  logic [QTY_W-1:0]   tab_qty_q   [NORD];
  logic [PRICE_W-1:0] tab_price_q [NORD];
  logic [LVL_W-1:0]   lvl_q       [NLVL];

  logic [ORDER_W:0]   size_q, size_d;
  logic               resp_valid_q, resp_valid_d;
  logic [1:0]         resp_code_q, resp_code_d;
  logic [QTY_W-1:0]   resp_qty_q, resp_qty_d;
  logic [CNT_W-1:0]   stable_cnt_q, stable_cnt_d;

  logic               accept;
  logic               wr_en;
  logic               lvl_add;
  logic [QTY_W-1:0]   wr_qty;
  logic [PRICE_W-1:0] wr_price;
  logic [PRICE_W-1:0] lvl_idx;
  logic [QTY_W-1:0]   amt;
  logic [QTY_W-1:0]   exec_amt;
  logic [1:0]         code;

  assign req_ready_out = (state_q == S_IDLE) && rst_in;
  assign accept        = req_ready_out && req_valid_in;
  assign exec_amt      = (qty_q < slot_qty_q) ? qty_q : slot_qty_q;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    resp_qty_d   = resp_qty_q;
    stable_cnt_d = (stable_cnt_q != '0) ? stable_cnt_q - CNT_W'(1) : stable_cnt_q;
    wr_en        = 1'b0;
    lvl_add      = 1'b0;
    wr_qty       = slot_qty_q;
    wr_price     = slot_price_q;
    lvl_idx      = slot_price_q;
    amt          = '0;
    code         = RC_OK;
    case (state_q)
      S_IDLE: begin
        if (accept && (req_op_in != OP_NOP)) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_COMMIT;
      S_COMMIT: begin
        state_d = S_IDLE;
        case (op_q)
          OP_ADD: begin
            if (qty_q == '0) code = RC_BAD_QTY;
            else if (slot_qty_q != '0) code = RC_DUP;
            else begin
              wr_en    = 1'b1;
              lvl_add  = 1'b1;
              wr_qty   = qty_q;
              wr_price = price_q;
              lvl_idx  = price_q;
              amt      = qty_q;
              size_d   = size_q + (ORDER_W+1)'(1);
            end
          end
          OP_CANCEL: begin
            if (slot_qty_q == '0) code = RC_UNKNOWN;
            else begin
              wr_en  = 1'b1;
              wr_qty = '0;
              amt    = slot_qty_q;
              size_d = size_q - (ORDER_W+1)'(1);
            end
          end
          OP_EXEC: begin
            if (slot_qty_q == '0) code = RC_UNKNOWN;
            else if (qty_q == '0) code = RC_BAD_QTY;
            else begin
              wr_en  = 1'b1;
              wr_qty = slot_qty_q - exec_amt;
              amt    = exec_amt;
              if (exec_amt == slot_qty_q) size_d = size_q - (ORDER_W+1)'(1);
            end
          end
          default: ;
        endcase
        resp_valid_d = 1'b1;
        resp_code_d  = code;
        resp_qty_d   = amt;
        // The tree needs PRICE_W+1 edges to absorb a level change.
        if (wr_en) stable_cnt_d = CNT_W'(PRICE_W + 1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      id_q         <= '0;
      price_q      <= '0;
      qty_q        <= '0;
      slot_qty_q   <= '0;
      slot_price_q <= '0;
      size_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      resp_qty_q   <= '0;
      stable_cnt_q <= '0;
      for (int i = 0; i < NORD; i++) begin
        tab_qty_q[ORDER_W'(i)]   <= '0;
        tab_price_q[ORDER_W'(i)] <= '0;
      end
      for (int i = 0; i < NLVL; i++) lvl_q[PRICE_W'(i)] <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      resp_qty_q   <= resp_qty_d;
      stable_cnt_q <= stable_cnt_d;
      if (accept) begin
        op_q    <= req_op_in;
        id_q    <= req_order_id_in;
        price_q <= req_price_in;
        qty_q   <= req_qty_in;
      end
      if (state_q == S_LOOKUP) begin
        slot_qty_q   <= tab_qty_q[id_q];
        slot_price_q <= tab_price_q[id_q];
      end
      if (wr_en) begin
        tab_qty_q[id_q]   <= wr_qty;
        tab_price_q[id_q] <= wr_price;
        lvl_q[lvl_idx]    <= lvl_add ? lvl_q[lvl_idx] + LVL_W'(amt)
                                     : lvl_q[lvl_idx] - LVL_W'(amt);
      end
    end
  end

  // Heap layout: node i has children 2i and 2i+1; indices NLVL..2*NLVL-1 are the leaf copies.
  logic [LVL_W-1:0]   leaf_q   [NLVL];
  logic               node_v_q [1:NLVL-1];
  logic [PRICE_W-1:0] node_p_q [1:NLVL-1];
  logic [LVL_W-1:0]   node_q_q [1:NLVL-1];
  logic               node_v_d [1:NLVL-1];
  logic [PRICE_W-1:0] node_p_d [1:NLVL-1];
  logic [LVL_W-1:0]   node_q_d [1:NLVL-1];

  logic               lv, rv, pick_r;
  logic [PRICE_W-1:0] lp, rp;
  logic [LVL_W-1:0]   lq, rq;

  always_comb begin
    lv     = 1'b0;
    rv     = 1'b0;
    lp     = '0;
    rp     = '0;
    lq     = '0;
    rq     = '0;
    pick_r = 1'b0;
    for (int i = 1; i < NLVL; i++) begin
      if (i >= NLVL / 2) begin
        lq = leaf_q[PRICE_W'(2*i - NLVL)];
        rq = leaf_q[PRICE_W'(2*i + 1 - NLVL)];
        lv = (lq != '0);
        rv = (rq != '0);
        lp = PRICE_W'(2*i - NLVL);
        rp = PRICE_W'(2*i + 1 - NLVL);
      end else begin
        lv = node_v_q[PRICE_W'(2*i)];
        rv = node_v_q[PRICE_W'(2*i + 1)];
        lp = node_p_q[PRICE_W'(2*i)];
        rp = node_p_q[PRICE_W'(2*i + 1)];
        lq = node_q_q[PRICE_W'(2*i)];
        rq = node_q_q[PRICE_W'(2*i + 1)];
      end
      pick_r = (IS_MAX != 0) ? rv : !lv;
      node_v_d[PRICE_W'(i)] = lv | rv;
      node_p_d[PRICE_W'(i)] = (lv | rv) ? (pick_r ? rp : lp) : '0;
      node_q_d[PRICE_W'(i)] = (lv | rv) ? (pick_r ? rq : lq) : '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NLVL; i++) leaf_q[PRICE_W'(i)] <= '0;
      for (int i = 1; i < NLVL; i++) begin
        node_v_q[PRICE_W'(i)] <= 1'b0;
        node_p_q[PRICE_W'(i)] <= '0;
        node_q_q[PRICE_W'(i)] <= '0;
      end
    end else begin
      leaf_q   <= lvl_q;
      node_v_q <= node_v_d;
      node_p_q <= node_p_d;
      node_q_q <= node_q_d;
    end
  end

  assign resp_valid_out  = resp_valid_q;
  assign resp_code_out   = resp_code_q;
  assign resp_qty_out    = resp_qty_q;
  assign best_valid_out  = node_v_q[1];
  assign best_price_out  = node_p_q[1];
  assign best_qty_out    = node_q_q[1];
  assign best_stable_out = (stable_cnt_q == '0);
  assign size_out        = size_q;

endmodule

// File: tb/tb_order_book_pipelined.sv
// tb/tb_order_book_pipelined.sv - scoreboard bench for bid and ask order book instances
`timescale 1ns/1ps
module tb_order_book_pipelined;
  localparam int PW = 7;
  localparam int OW = 8;
  localparam int QW = 16;
  localparam int LW = QW + OW;

  localparam logic [1:0] NOP = 2'd0, ADD = 2'd1, CAN = 2'd2, EXE = 2'd3;
  localparam logic [1:0] OK = 2'd0, UNK = 2'd1, DUP = 2'd2, BADQ = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [OW-1:0] req_id = '0;
  logic [PW-1:0] req_price = '0;
  logic [QW-1:0] req_qty = '0;

  logic          b_ready, b_rv, b_bv, b_bs;
  logic [1:0]    b_rc;
  logic [QW-1:0] b_rq;
  logic [PW-1:0] b_bp;
  logic [LW-1:0] b_bq;
  logic [OW:0]   b_size;
  logic          a_ready, a_rv, a_bv, a_bs;
  logic [1:0]    a_rc;
  logic [QW-1:0] a_rq;
  logic [PW-1:0] a_bp;
  logic [LW-1:0] a_bq;
  logic [OW:0]   a_size;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic [QW+1:0] exp_q [$];

  order_book_pipelined #(.PRICE_W(PW), .ORDER_W(OW), .QTY_W(QW), .IS_MAX(1)) u_bid (
    .clk_in(clk), .rst_in(rst_n), .req_valid_in(req_valid), .req_ready_out(b_ready),
    .req_op_in(req_op), .req_order_id_in(req_id), .req_price_in(req_price), .req_qty_in(req_qty),
    .resp_valid_out(b_rv), .resp_code_out(b_rc), .resp_qty_out(b_rq),
    .best_valid_out(b_bv), .best_price_out(b_bp), .best_qty_out(b_bq),
    .best_stable_out(b_bs), .size_out(b_size));

  order_book_pipelined #(.PRICE_W(PW), .ORDER_W(OW), .QTY_W(QW), .IS_MAX(0)) u_ask (
    .clk_in(clk), .rst_in(rst_n), .req_valid_in(req_valid), .req_ready_out(a_ready),
    .req_op_in(req_op), .req_order_id_in(req_id), .req_price_in(req_price), .req_qty_in(req_qty),
    .resp_valid_out(a_rv), .resp_code_out(a_rc), .resp_qty_out(a_rq),
    .best_valid_out(a_bv), .best_price_out(a_bp), .best_qty_out(a_bq),
    .best_stable_out(a_bs), .size_out(a_size));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (b_rv) resp_cnt <= resp_cnt + 1;

  // Drives one request; the expected response is queued at drive time and popped when it appears.
  task automatic do_req(input logic [1:0] op, input logic [OW-1:0] id, input logic [PW-1:0] pr,
                        input logic [QW-1:0] q, input logic [1:0] ecode, input logic [QW-1:0] eqty);
    logic [QW+1:0] e;
    int n;
    @(negedge clk);
    n = 0;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!b_ready) begin errors++; $display("FAIL ready_timeout got %0b want 1", b_ready); end
    req_valid = 1'b1; req_op = op; req_id = id; req_price = pr; req_qty = q;
    if (op != NOP) exp_q.push_back({ecode, eqty});
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (op != NOP) begin
      n = 0;
      @(negedge clk);
      while (!b_rv && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (!b_rv) begin
        errors++; $display("FAIL resp_timeout op %0d got none want response", op);
      end else begin
        checks++;
        if (n != 2) begin errors++; $display("FAIL resp_latency got %0d want 2", n); end
        e = exp_q.pop_front();
        checks++;
        if ({b_rc, b_rq} !== e)
          begin errors++; $display("FAIL resp op %0d id %0d got code %0d qty %0d want code %0d qty %0d",
                                   op, id, b_rc, b_rq, e[QW+1:QW], e[QW-1:0]); end
      end
    end
  endtask

  task automatic wait_stable();
    int n;
    n = 0;
    @(negedge clk);
    while (!b_bs && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!b_bs) begin errors++; $display("FAIL stable_timeout got %0b want 1", b_bs); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({b_ready, b_rv, b_rc, b_rq, b_size} !== '0)
      begin errors++; $display("FAIL reset_ctrl got rdy %0b rv %0b rc %0d rq %0d size %0d want 0", b_ready, b_rv, b_rc, b_rq, b_size); end
    checks++;
    if ({b_bv, b_bp, b_bq, b_bs} !== {1'b0, 7'd0, 24'd0, 1'b1})
      begin errors++; $display("FAIL reset_best got v %0b p %0d q %0d s %0b want 0 0 0 1", b_bv, b_bp, b_bq, b_bs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", b_ready); end
  endtask

  task automatic test_add_cancel();
    do_req(ADD, 8'd5, 7'd40, 16'd100, OK, 16'd100);
    do_req(ADD, 8'd6, 7'd42, 16'd7, OK, 16'd7);
    checks++;
    if (b_size !== 9'd2) begin errors++; $display("FAIL size_two got %0d want 2", b_size); end
    wait_stable();
    checks++;
    if ({b_bv, b_bp, b_bq} !== {1'b1, 7'd42, 24'd7})
      begin errors++; $display("FAIL bid_best_42 got %0b %0d %0d want 1 42 7", b_bv, b_bp, b_bq); end
    checks++;
    if ({a_bv, a_bp, a_bq} !== {1'b1, 7'd40, 24'd100})
      begin errors++; $display("FAIL ask_best_40 got %0b %0d %0d want 1 40 100", a_bv, a_bp, a_bq); end
    do_req(CAN, 8'd6, 7'd0, 16'd0, OK, 16'd7);
    checks++;
    if ({b_size, b_bs} !== {9'd1, 1'b0})
      begin errors++; $display("FAIL cancel_commit got size %0d stable %0b want 1 0", b_size, b_bs); end
    repeat (7) @(negedge clk);
    checks++;
    if ({b_bp, b_bs} !== {7'd42, 1'b0})
      begin errors++; $display("FAIL cancel_k7 got p %0d s %0b want 42 0", b_bp, b_bs); end
    @(negedge clk);
    checks++;
    if ({b_bv, b_bp, b_bq, b_bs} !== {1'b1, 7'd40, 24'd100, 1'b1})
      begin errors++; $display("FAIL cancel_k8 got %0b %0d %0d s %0b want 1 40 100 1", b_bv, b_bp, b_bq, b_bs); end
  endtask

  task automatic test_min_side();
    do_req(ADD, 8'd7, 7'd10, 16'd5, OK, 16'd5);
    do_req(ADD, 8'd8, 7'd3, 16'd9, OK, 16'd9);
    wait_stable();
    checks++;
    if ({a_bv, a_bp, a_bq} !== {1'b1, 7'd3, 24'd9})
      begin errors++; $display("FAIL ask_best_3 got %0b %0d %0d want 1 3 9", a_bv, a_bp, a_bq); end
    checks++;
    if ({b_bv, b_bp, b_bq, b_size} !== {1'b1, 7'd40, 24'd100, 9'd3})
      begin errors++; $display("FAIL bid_best_40 got %0b %0d %0d size %0d want 1 40 100 3", b_bv, b_bp, b_bq, b_size); end
  endtask

  task automatic test_execute();
    do_req(EXE, 8'd5, 7'd0, 16'd150, OK, 16'd100);
    checks++;
    if (b_size !== 9'd2) begin errors++; $display("FAIL exec_size got %0d want 2", b_size); end
    wait_stable();
    checks++;
    if ({b_bv, b_bp, b_bq} !== {1'b1, 7'd10, 24'd5})
      begin errors++; $display("FAIL exec_level40_empty got %0b %0d %0d want 1 10 5", b_bv, b_bp, b_bq); end
    do_req(EXE, 8'd5, 7'd0, 16'd1, UNK, 16'd0);
  endtask

  task automatic test_rejects();
    int r0;
    do_req(ADD, 8'd7, 7'd20, 16'd50, DUP, 16'd0);
    checks++;
    if ({b_bs, b_size} !== {1'b1, 9'd2})
      begin errors++; $display("FAIL dup_no_change got stable %0b size %0d want 1 2", b_bs, b_size); end
    do_req(ADD, 8'd9, 7'd20, 16'd0, BADQ, 16'd0);
    do_req(EXE, 8'd8, 7'd0, 16'd0, BADQ, 16'd0);
    do_req(CAN, 8'd99, 7'd0, 16'd0, UNK, 16'd0);
    @(negedge clk);
    r0 = resp_cnt;
    do_req(NOP, 8'd1, 7'd1, 16'd1, OK, 16'd0);
    repeat (4) @(negedge clk);
    checks++;
    if ({b_ready, resp_cnt} !== {1'b1, r0})
      begin errors++; $display("FAIL nop got ready %0b resps %0d want 1 %0d", b_ready, resp_cnt, r0); end
    checks++;
    if ({b_bv, b_bp, b_bq, b_bs} !== {1'b1, 7'd10, 24'd5, 1'b1})
      begin errors++; $display("FAIL rejects_best got %0b %0d %0d s %0b want 1 10 5 1", b_bv, b_bp, b_bq, b_bs); end
    do_req(EXE, 8'd8, 7'd0, 16'd4, OK, 16'd4);
    wait_stable();
    checks++;
    if ({a_bv, a_bp, a_bq, b_size} !== {1'b1, 7'd3, 24'd5, 9'd2})
      begin errors++; $display("FAIL partial_exec got %0b %0d %0d size %0d want 1 3 5 2", a_bv, a_bp, a_bq, b_size); end
  endtask

  task automatic test_empty();
    do_req(CAN, 8'd7, 7'd0, 16'd0, OK, 16'd5);
    do_req(CAN, 8'd8, 7'd0, 16'd0, OK, 16'd5);
    wait_stable();
    checks++;
    if ({b_bv, b_bp, b_bq, a_bv, a_bp, a_bq, b_size} !== '0)
      begin errors++; $display("FAIL empty_book got bid %0b %0d %0d ask %0b %0d %0d size %0d want 0",
                               b_bv, b_bp, b_bq, a_bv, a_bp, a_bq, b_size); end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int r0;
    int n;
    logic [QW+1:0] e;
    @(negedge clk);
    r0 = resp_cnt;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_op = ADD; req_id = OW'(20 + k); req_price = PW'(60 + k); req_qty = QW'(k + 1);
      if (k > 0) @(negedge clk);
      n = 0;
      while (!b_ready && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (!b_ready) begin errors++; $display("FAIL b2b_ready_timeout k %0d got 0 want 1", k); end
      if (k > 0) begin
        checks++;
        if (!b_rv) begin
          errors++; $display("FAIL b2b_resp_with_ready k %0d got 0 want 1", k);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({b_rc, b_rq} !== e)
            begin errors++; $display("FAIL b2b_resp got %0d %0d want %0d %0d", b_rc, b_rq, e[QW+1:QW], e[QW-1:0]); end
        end
      end
      acc[k] = cyc;
      exp_q.push_back({OK, QW'(k + 1)});
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!b_rv && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!b_rv) begin
      errors++; $display("FAIL b2b_last_resp got none want response");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({b_rc, b_rq} !== e)
        begin errors++; $display("FAIL b2b_last got %0d %0d want %0d %0d", b_rc, b_rq, e[QW+1:QW], e[QW-1:0]); end
    end
    @(negedge clk);
    checks++;
    if ({b_rv, resp_cnt - r0, b_size} !== {1'b0, 32'd3, 9'd3})
      begin errors++; $display("FAIL b2b_pulses got rv %0b resps %0d size %0d want 0 3 3", b_rv, resp_cnt - r0, b_size); end
    checks++;
    if ((acc[1] - acc[0] != 3) || (acc[2] - acc[1] != 3))
      begin errors++; $display("FAIL b2b_spacing got %0d %0d want 3 3", acc[1] - acc[0], acc[2] - acc[1]); end
  endtask

  task automatic test_reset_mid();
    int r0;
    @(negedge clk);
    r0 = resp_cnt;
    req_valid = 1'b1; req_op = ADD; req_id = 8'd30; req_price = 7'd50; req_qty = 16'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_ready, b_rv, b_rc, b_rq, b_size} !== '0)
      begin errors++; $display("FAIL midreset_ctrl got rdy %0b rv %0b rc %0d rq %0d size %0d want 0", b_ready, b_rv, b_rc, b_rq, b_size); end
    checks++;
    if ({b_bv, b_bp, b_bq, b_bs} !== {1'b0, 7'd0, 24'd0, 1'b1})
      begin errors++; $display("FAIL midreset_best got %0b %0d %0d s %0b want 0 0 0 1", b_bv, b_bp, b_bq, b_bs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %0b want 1", b_ready); end
    repeat (5) @(negedge clk);
    checks++;
    if (resp_cnt != r0) begin errors++; $display("FAIL midreset_dropped got %0d resps want %0d", resp_cnt, r0); end
    do_req(ADD, 8'd20, 7'd60, 16'd5, OK, 16'd5);
    checks++;
    if (b_size !== 9'd1) begin errors++; $display("FAIL post_reset_size got %0d want 1", b_size); end
  endtask

  initial begin
    test_reset();
    test_add_cancel();
    test_min_side();
    test_execute();
    test_rejects();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
